// File: rtl/conv_transposed_2d_zero_insert_streamer_pkg.sv
// Shared types, data width and geometry helpers for the transposed-conv zero-insert streamer.
package conv_t_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Border width of zeros around the dilated plane
    function automatic int unsigned calc_b(input int unsigned k, input int unsigned pad);
        return k - 1 - pad;
    endfunction

    function automatic int unsigned calc_exp(input int unsigned n_in, input int unsigned k,
                                             input int unsigned stride, input int unsigned pad,
                                             input int unsigned out_pad);
        return (n_in - 1) * stride + 1 + 2 * calc_b(k, pad) + out_pad;
    endfunction

    function automatic int unsigned calc_h_exp(input int unsigned h_in, input int unsigned k,
                                               input int unsigned stride, input int unsigned pad,
                                               input int unsigned out_pad);
        return calc_exp(h_in, k, stride, pad, out_pad);
    endfunction

    function automatic int unsigned calc_w_exp(input int unsigned w_in, input int unsigned k,
                                               input int unsigned stride, input int unsigned pad,
                                               input int unsigned out_pad);
        return calc_exp(w_in, k, stride, pad, out_pad);
    endfunction

    // clog2(max(h_exp, w_exp)), never below 1 bit
    function automatic int unsigned cnt_w(input int unsigned h_exp, input int unsigned w_exp);
        int unsigned m;
        int unsigned w;
        m = (h_exp > w_exp) ? h_exp : w_exp;
        w = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < m) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/conv_transposed_2d_zero_insert_streamer_if.sv
// Input/output stream bundle; zero_tag_out exists only when CONV_T_ZERO_TAG_EN is defined.
interface conv_transposed_2d_zero_insert_streamer_if
    import conv_t_pkg::*;
#(
    parameter int unsigned DW = DATA_W
);
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] input_data;
    logic          valid_out;
    logic          ready_out;
    logic [DW-1:0] output_data;
    logic          sof_out;
    logic          eol_out;
    logic          eof_out;
`ifdef CONV_T_ZERO_TAG_EN
    logic          zero_tag_out;
`endif

    modport slave (
        input  valid_in, input_data, ready_out,
        output ready_in, valid_out, output_data, sof_out, eol_out, eof_out
`ifdef CONV_T_ZERO_TAG_EN
        , output zero_tag_out
`endif
    );

    modport master (
        output valid_in, input_data, ready_out,
        input  ready_in, valid_out, output_data, sof_out, eol_out, eof_out
`ifdef CONV_T_ZERO_TAG_EN
        , input zero_tag_out
`endif
    );

endinterface

// File: rtl/conv_transposed_2d_zero_insert_streamer_pos_counter.sv
// One-dimension position counter over the expanded axis; tracks stride phase and sample index.
module conv_t_pos_counter #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned STRIDE = 2,
    parameter int unsigned B      = 2,
    parameter int unsigned N_EXP  = 11,
    parameter int unsigned W      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         is_real,
    output logic         is_last
);

    logic [W-1:0] phase_q;
    logic [W-1:0] smp_q;
    logic         in_body_c;

    generate
        if (B == 0) begin : g_no_border
            assign in_body_c = 1'b1;
        end else begin : g_border
            assign in_body_c = (idx >= W'(B));
        end
    endgenerate

    assign is_last = (idx == W'(N_EXP - 1));
    assign is_real = in_body_c && (phase_q == '0) && (smp_q < W'(N_IN));

    // smp_q holds (idx-B)/STRIDE without a divider: bumped each time the phase wraps
    always_ff @(posedge clk) begin
        if (rst_n) begin
            idx     <= '0;
            phase_q <= '0;
            smp_q   <= '0;
        end else if (inc) begin
            if (is_last) begin
                idx     <= '0;
                phase_q <= '0;
                smp_q   <= '0;
            end else begin
                idx <= idx + W'(1);
                if (in_body_c) begin
                    if (phase_q == W'(STRIDE - 1)) begin
                        phase_q <= '0;
                        smp_q   <= smp_q + W'(1);
                    end else begin
                        phase_q <= phase_q + W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/conv_transposed_2d_zero_insert_streamer.sv
// Expands a raster input plane into its zero-inserted, padded equivalent for a stride-1 KxK conv.
// Optional zero_tag_out under CONV_T_ZERO_TAG_EN.
module conv_transposed_2d_zero_insert_streamer
    import conv_t_pkg::*;
#(
    parameter int unsigned H_IN    = 4,
    parameter int unsigned W_IN    = 6,
    parameter int unsigned K       = 3,
    parameter int unsigned STRIDE  = 2,
    parameter int unsigned PAD     = 0,
    parameter int unsigned OUT_PAD = 0
) (
    input logic clk,
    input logic rst_n,
    conv_transposed_2d_zero_insert_streamer_if.slave stream
);

    localparam int unsigned BORDER = calc_b(K, PAD);
    localparam int unsigned H_EXP  = calc_h_exp(H_IN, K, STRIDE, PAD, OUT_PAD);
    localparam int unsigned W_EXP  = calc_w_exp(W_IN, K, STRIDE, PAD, OUT_PAD);
    localparam int unsigned CW     = cnt_w(H_EXP, W_EXP);

    state_t state_q, state_d;

    logic [CW-1:0] row_idx, col_idx;
    logic          row_real, col_real, row_last, col_last;
    logic          pos_real_c, pos_last_c, load_ok_c;
    logic          advance_c, take_c, ready_in_c;

    logic              valid_q, sof_q, eol_q, eof_q;
    logic [DATA_W-1:0] data_q;

    conv_t_pos_counter #(
        .N_IN(H_IN), .STRIDE(STRIDE), .B(BORDER), .N_EXP(H_EXP), .W(CW)
    ) u_row (
        .clk(clk), .rst_n(rst_n), .inc(advance_c && col_last),
        .idx(row_idx), .is_real(row_real), .is_last(row_last)
    );

    conv_t_pos_counter #(
        .N_IN(W_IN), .STRIDE(STRIDE), .B(BORDER), .N_EXP(W_EXP), .W(CW)
    ) u_col (
        .clk(clk), .rst_n(rst_n), .inc(advance_c),
        .idx(col_idx), .is_real(col_real), .is_last(col_last)
    );

    assign pos_real_c = row_real && col_real;
    assign pos_last_c = row_last && col_last;
    assign load_ok_c  = !valid_q || stream.ready_out;

    always_ff @(posedge clk) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state plus per-cycle advance/consume decisions
    always_comb begin
        state_d    = state_q;
        advance_c  = 1'b0;
        take_c     = 1'b0;
        ready_in_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (stream.valid_in) state_d = STREAM;
            end
            STREAM: begin
                if (load_ok_c) begin
                    if (!pos_real_c) begin
                        advance_c = 1'b1;
                    end else begin
                        ready_in_c = 1'b1;
                        if (stream.valid_in) begin
                            advance_c = 1'b1;
                            take_c    = 1'b1;
                        end
                    end
                    if (advance_c && pos_last_c) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (load_ok_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single output register stage; holds while stalled, empties on a bubble
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (load_ok_c) begin
            valid_q <= advance_c;
            if (advance_c) begin
                data_q <= take_c ? stream.input_data : '0;
                sof_q  <= (row_idx == '0) && (col_idx == '0);
                eol_q  <= col_last;
                eof_q  <= pos_last_c;
            end
        end
    end

`ifdef CONV_T_ZERO_TAG_EN
    logic zero_tag_q;

    always_ff @(posedge clk) begin
        if (rst_n)                        zero_tag_q <= 1'b0;
        else if (load_ok_c && advance_c)  zero_tag_q <= !take_c;
    end

    assign stream.zero_tag_out = zero_tag_q;
`endif

    assign stream.ready_in    = ready_in_c;
    assign stream.valid_out   = valid_q;
    assign stream.output_data = data_q;
    assign stream.sof_out     = sof_q;
    assign stream.eol_out     = eol_q;
    assign stream.eof_out     = eof_q;

endmodule

// File: tb/tb_conv_transposed_2d_zero_insert_streamer.sv
// Directed bench: default geometry (11x15) and PAD=2/OUT_PAD=1 geometry (8x12) side by side.
module tb_conv_transposed_2d_zero_insert_streamer;
    import conv_t_pkg::*;

    typedef struct {
        int          sel;
        int          idx;
        logic [31:0] data;
        logic [2:0]  flg;   // {sof, eol, eof}
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          sel;
    logic        v_in, r_out;
    logic [31:0] d_in;

    conv_transposed_2d_zero_insert_streamer_if if0 ();
    conv_transposed_2d_zero_insert_streamer_if if1 ();

    conv_transposed_2d_zero_insert_streamer dut0 (
        .clk(clk), .rst_n(rst_n), .stream(if0.slave)
    );

    conv_transposed_2d_zero_insert_streamer #(
        .H_IN(4), .W_IN(6), .K(3), .STRIDE(2), .PAD(2), .OUT_PAD(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .stream(if1.slave)
    );

    assign if0.valid_in   = v_in && (sel == 0);
    assign if1.valid_in   = v_in && (sel == 1);
    assign if0.input_data = d_in;
    assign if1.input_data = d_in;
    assign if0.ready_out  = r_out;
    assign if1.ready_out  = r_out;

    logic        o_valid, o_ready_in;
    logic [31:0] o_data;
    logic [2:0]  o_flg;
`ifdef CONV_T_ZERO_TAG_EN
    logic        o_tag;
    logic        cap_tag [0:255];
`endif

    always_comb begin
        if (sel == 0) begin
            o_valid    = if0.valid_out;
            o_ready_in = if0.ready_in;
            o_data     = if0.output_data;
            o_flg      = {if0.sof_out, if0.eol_out, if0.eof_out};
`ifdef CONV_T_ZERO_TAG_EN
            o_tag      = if0.zero_tag_out;
`endif
        end else begin
            o_valid    = if1.valid_out;
            o_ready_in = if1.ready_in;
            o_data     = if1.output_data;
            o_flg      = {if1.sof_out, if1.eol_out, if1.eof_out};
`ifdef CONV_T_ZERO_TAG_EN
            o_tag      = if1.zero_tag_out;
`endif
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cap_data [0:255];
    logic [2:0]  cap_flg  [0:255];
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference geometry: sel 0 -> B=2, 11x15; sel 1 -> B=0, 8x12
    function automatic void model(input int s, input int i, output logic [31:0] d,
                                  output logic is_re, output logic [2:0] flg);
        int he, we, b, r, c, rr, cc;
        he = (s == 0) ? 11 : 8;
        we = (s == 0) ? 15 : 12;
        b  = (s == 0) ? 2 : 0;
        r  = i / we;
        c  = i % we;
        rr = r - b;
        cc = c - b;
        is_re = (rr >= 0) && (cc >= 0) && (rr % 2 == 0) && (cc % 2 == 0)
                && (rr / 2 < 4) && (cc / 2 < 6);
        d   = is_re ? 32'((rr / 2) * 6 + (cc / 2) + 1) : 32'd0;
        flg = {i == 0, c == we - 1, i == he * we - 1};
    endfunction

    task automatic run_plane(input int s, input int stall, input int gap, input int rst_at,
                             output int n_out, output int n_cyc, output int n_in);
        int          next_in;
        int          gapc;
        int          total;
        logic        pv;
        logic [34:0] pvals;
        next_in = 1;
        gapc    = 0;
        pv      = 1'b0;
        pvals   = '0;
        total   = (s == 0) ? 165 : 96;
        sel     = s;
        n_out   = 0;
        n_cyc   = 0;
        n_in    = 0;
        while (n_out < total && n_cyc < 2000) begin
            @(negedge clk);
            r_out = (stall != 0) ? ((n_cyc % 4 == 0) || (n_cyc % 4 == 3)) : 1'b1;
            d_in  = 32'(next_in);
            v_in  = (next_in <= 24);
            #1;
            if (gap != 0 && next_in == 7 && gapc < 3 && o_ready_in) begin
                v_in = 1'b0;
                gapc++;
            end
            #1;
            if (pv) chk("stall_hold", {o_valid, o_data, o_flg}, {1'b1, pvals});
            if (o_valid && !r_out) chk("ready_in_while_stalled", 64'(o_ready_in), 64'd0);
            pv    = o_valid && !r_out;
            pvals = {o_data, o_flg};
            if (o_valid && r_out) begin
                cap_data[n_out] = o_data;
                cap_flg[n_out]  = o_flg;
`ifdef CONV_T_ZERO_TAG_EN
                cap_tag[n_out]  = o_tag;
`endif
                n_out++;
            end
            if (v_in && o_ready_in) begin
                next_in++;
                n_in++;
            end
            n_cyc++;
            if (rst_at > 0 && n_out == rst_at) return;
        end
        if (n_out < total) chk("plane_timeout", 64'(n_out), 64'(total));
        if (gap != 0) chk("gap_cycles", 64'(gapc), 64'd3);
        @(negedge clk);
        v_in = 1'b0;
    endtask

    task automatic check_plane(input int s, input int n_out, input int n_in);
        int          total;
        int          n_zero;
        logic [31:0] d;
        logic        is_re;
        logic [2:0]  flg;
        total  = (s == 0) ? 165 : 96;
        n_zero = 0;
        chk("out_count", 64'(n_out), 64'(total));
        chk("in_count", 64'(n_in), 64'd24);
        for (int i = 0; i < total && i < n_out; i++) begin
            model(s, i, d, is_re, flg);
            chk($sformatf("plane%0d_out%0d", s, i), {cap_data[i], 29'd0, cap_flg[i]},
                {d, 29'd0, flg});
`ifdef CONV_T_ZERO_TAG_EN
            chk($sformatf("plane%0d_tag%0d", s, i), 64'(cap_tag[i]), 64'(!is_re));
            if (cap_tag[i]) n_zero++;
`endif
        end
`ifdef CONV_T_ZERO_TAG_EN
        chk("zero_tag_total", 64'(n_zero), 64'(total - 24));
`endif
    endtask

    task automatic check_table(input int s);
        foreach (vecs[j]) begin
            if (vecs[j].sel == s) begin
                chk($sformatf("vec%0d_idx%0d", s, vecs[j].idx),
                    {cap_data[vecs[j].idx], 29'd0, cap_flg[vecs[j].idx]},
                    {vecs[j].data, 29'd0, vecs[j].flg});
            end
        end
    endtask

    function automatic void add_vec(input int s, input int i, input int d, input logic [2:0] f);
        vec_t v;
        v.sel  = s;
        v.idx  = i;
        v.data = 32'(d);
        v.flg  = f;
        vecs.push_back(v);
    endfunction

    initial begin
        int n_out, n_cyc, n_in;

        // Hand-computed spot values (index = row*W_EXP + col)
        add_vec(0, 0,   0,  3'b100);
        add_vec(0, 14,  0,  3'b010);
        add_vec(0, 15,  0,  3'b000);
        add_vec(0, 30,  0,  3'b000);
        add_vec(0, 32,  1,  3'b000);
        add_vec(0, 33,  0,  3'b000);
        add_vec(0, 34,  2,  3'b000);
        add_vec(0, 42,  6,  3'b000);
        add_vec(0, 44,  0,  3'b010);
        add_vec(0, 47,  0,  3'b000);
        add_vec(0, 122, 19, 3'b000);
        add_vec(0, 132, 24, 3'b000);
        add_vec(0, 134, 0,  3'b010);
        add_vec(0, 157, 0,  3'b000);
        add_vec(0, 164, 0,  3'b011);
        add_vec(1, 0,   1,  3'b100);
        add_vec(1, 2,   2,  3'b000);
        add_vec(1, 10,  6,  3'b000);
        add_vec(1, 11,  0,  3'b010);
        add_vec(1, 24,  7,  3'b000);
        add_vec(1, 84,  0,  3'b000);
        add_vec(1, 95,  0,  3'b011);

        sel   = 0;
        v_in  = 1'b0;
        r_out = 1'b1;
        d_in  = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid_out", 64'(if0.valid_out), 64'd0);
        chk("reset_ready_in", 64'(if0.ready_in), 64'd0);
        chk("reset_data", 64'(if0.output_data), 64'd0);
        chk("reset_flags", 64'({if0.sof_out, if0.eol_out, if0.eof_out}), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);

        // Full-rate plane
        run_plane(0, 0, 0, 0, n_out, n_cyc, n_in);
        check_plane(0, n_out, n_in);
        check_table(0);
        chk("full_rate_cycles", 64'(n_cyc), 64'd167);

        // Output back-pressure 1,0,0,1
        run_plane(0, 1, 0, 0, n_out, n_cyc, n_in);
        check_plane(0, n_out, n_in);

        // Input bubble before sample 7
        run_plane(0, 0, 1, 0, n_out, n_cyc, n_in);
        check_plane(0, n_out, n_in);

        // Reset mid-plane, then a fresh plane
        run_plane(0, 0, 0, 50, n_out, n_cyc, n_in);
        v_in  = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midreset_valid_out", 64'(if0.valid_out), 64'd0);
        chk("midreset_ready_in", 64'(if0.ready_in), 64'd0);
        chk("midreset_data_flags",
            64'({if0.output_data, if0.sof_out, if0.eol_out, if0.eof_out}), 64'd0);
        rst_n = 1'b0;
        run_plane(0, 0, 0, 0, n_out, n_cyc, n_in);
        check_plane(0, n_out, n_in);
        chk("post_reset_cycles", 64'(n_cyc), 64'd167);

        // PAD=2, OUT_PAD=1 geometry
        run_plane(1, 0, 0, 0, n_out, n_cyc, n_in);
        check_plane(1, n_out, n_in);
        check_table(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
